perm_arbiter_ti: RTL and testbench

//  Shares one 3-share threshold-implementation Ascon permutation core between two masked

---
 rtl/ascon_ti_pkg.sv | 7 +
 rtl/perm_arbiter_ti_if.sv | 16 +
 rtl/rr_arb2.sv | 8 +
 rtl/perm_arbiter_ti.sv | 79 +++++++
 tb/tb_perm_arbiter_ti.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/ascon_ti_pkg.sv
// ascon_ti_pkg: share width, round limits and arbiter state encoding shared by perm_arbiter_ti
package ascon_ti_pkg;
  localparam int SW = 320;
  localparam int MAX_RND = 12;
  localparam int RW = 5;
  typedef enum logic [1:0] {IDLE, RUN, DONE, REJ} state_t;
endpackage

// File: rtl/perm_arbiter_ti_if.sv
// perm_arbiter_ti_if: requester bus (req/shares/rounds -> gnt/ack/err/res_st/busy) and core bus (perm_start/rnd/in -> perm_out/done); slave = arbiter, master = requesters and core
interface perm_arbiter_ti_if;
  import ascon_ti_pkg::*;
  logic [1:0] req, gnt, ack, err;
  logic [3*SW-1:0] req0_st, req1_st, res_st, perm_in, perm_out;
  logic [RW-1:0] req0_rnd, req1_rnd, perm_rnd;
  logic busy, perm_start, perm_done;
  modport slave (
    input req, req0_st, req1_st, req0_rnd, req1_rnd, perm_out, perm_done,
    output gnt, ack, err, res_st, busy, perm_start, perm_rnd, perm_in
  );
  modport master (
    output req, req0_st, req1_st, req0_rnd, req1_rnd, perm_out, perm_done,
    input gnt, ack, err, res_st, busy, perm_start, perm_rnd, perm_in
  );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: 2-way round-robin picker; req -> one-hot sel, ptr chooses the winner when both request
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] sel
);
  assign sel = &req ? (ptr ? 2'b10 : 2'b01) : req;
endmodule

// File: rtl/perm_arbiter_ti.sv
// perm_arbiter_ti: shares one masked Ascon permutation core between two requesters (clk, active-low async rst, bus = slave side of perm_arbiter_ti_if)
module perm_arbiter_ti
  import ascon_ti_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic rst,
  perm_arbiter_ti_if.slave bus
);
  localparam int WW = $clog2(TIMEOUT + 1);
  state_t state_q, state_d;
  logic ptr_q, ptr_d, own_q, own_d;
  logic [3*SW-1:0] buf_q, buf_d, res_q, res_d;
  logic [RW-1:0] rnd_q, rnd_d, rnd_in;
  logic [WW-1:0] wd_q, wd_d;
  logic [1:0] sel, own_oh;
  logic rnd_ok, expire;
  rr_arb2 u_arb (.req(bus.req), .ptr(ptr_q), .sel(sel));
  assign rnd_in = sel[1] ? bus.req1_rnd : bus.req0_rnd;
  assign rnd_ok = rnd_in != '0 && rnd_in <= RW'(MAX_RND);
  assign expire = wd_q == WW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      ptr_q <= 1'b0;
      own_q <= 1'b0;
      buf_q <= '0;
      rnd_q <= '0;
      res_q <= '0;
      wd_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      own_q <= own_d;
      buf_q <= buf_d;
      rnd_q <= rnd_d;
      res_q <= res_d;
      wd_q <= wd_d;
    end
  // a watchdog expiry reuses REJ so the abort err pulse and pointer hand-over match a rejection
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    own_d = own_q;
    buf_d = buf_q;
    rnd_d = rnd_q;
    res_d = res_q;
    wd_d = '0;
    case (state_q)
      IDLE: if (|sel) begin
        own_d = sel[1];
        state_d = rnd_ok ? RUN : REJ;
        buf_d = rnd_ok ? (sel[1] ? bus.req1_st : bus.req0_st) : buf_q;
        rnd_d = rnd_ok ? rnd_in : rnd_q;
      end
      RUN: begin
        wd_d = wd_q + WW'(1);
        res_d = bus.perm_done ? bus.perm_out : res_q;
        state_d = bus.perm_done ? DONE : expire ? REJ : RUN;
      end
      default: begin
        ptr_d = ~own_q;
        state_d = IDLE;
      end
    endcase
  end
  always_comb begin
    own_oh = own_q ? 2'b10 : 2'b01;
    bus.gnt = (state_q == RUN || state_q == DONE) ? own_oh : 2'b00;
    bus.ack = state_q == DONE ? own_oh : 2'b00;
    bus.err = state_q == REJ ? own_oh : 2'b00;
    bus.busy = state_q != IDLE;
    bus.perm_start = state_q == RUN;
  end
  assign bus.perm_in = buf_q;
  assign bus.perm_rnd = rnd_q;
  assign bus.res_st = res_q;
endmodule

// File: tb/tb_perm_arbiter_ti.sv
// tb_perm_arbiter_ti: table, hand-written and randomized checks of perm_arbiter_ti against a transaction-level model
module tb_perm_arbiter_ti;
  import ascon_ti_pkg::*;
  localparam int TIMEOUT = 64;
  typedef struct {
    logic [1:0] rq;
    logic [4:0] r0, r1;
    int d;
    logic drop;
    int ecyc;
    logic [1:0] eack, eerr;
  } vec_t;
  logic clk, rst;
  int n_chk, n_fail, core_delay, run_cnt;
  logic stray_en, ptr_m;
  logic [3*SW-1:0] core_res, last_res;
  vec_t tbl [10];
  perm_arbiter_ti_if bus ();
  perm_arbiter_ti #(.TIMEOUT(TIMEOUT)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  // core stand-in: done after core_delay RUN cycles (0 = stall); perm_out only carries the result on done
  initial begin
    run_cnt = 0;
    bus.perm_done = 1'b0;
    bus.perm_out = '0;
    forever begin
      @(negedge clk);
      run_cnt = bus.perm_start ? run_cnt + 1 : 0;
      bus.perm_done = (bus.perm_start && core_delay > 0 && run_cnt == core_delay) || (!bus.perm_start && stray_en);
      bus.perm_out = bus.perm_done ? core_res : ~core_res;
    end
  end
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic chkw(input string nm, input logic [3*SW-1:0] got, input logic [3*SW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got low64 %0h expected low64 %0h", nm, got[63:0], exp[63:0]);
    end
  endtask
  function automatic logic [3*SW-1:0] rnd_st();
    logic [3*SW-1:0] v;
    for (int i = 0; i < 3 * SW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction
  task automatic apply(input logic [1:0] rq, input logic [4:0] r0, input logic [4:0] r1, input int d,
                       input logic drop, input int ecyc, input logic [1:0] eack, input logic [1:0] eerr);
    logic [3*SW-1:0] s0, s1, cres, exp_in;
    logic [4:0] exp_rnd;
    logic [1:0] ew;
    int cyc, nstart;
    logic seen;
    s0 = rnd_st();
    s1 = rnd_st();
    cres = rnd_st();
    ew = eack | eerr;
    exp_in = ew[1] ? s1 : s0;
    exp_rnd = ew[1] ? r1 : r0;
    @(negedge clk);
    core_delay = d;
    core_res = cres;
    bus.req0_st = s0;
    bus.req1_st = s1;
    bus.req0_rnd = r0;
    bus.req1_rnd = r1;
    bus.req = rq;
    cyc = 0;
    nstart = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (bus.perm_start) begin
        nstart++;
        chkw("perm_in", bus.perm_in, exp_in);
        chk("perm_rnd", 64'(bus.perm_rnd), 64'(exp_rnd));
        chk("gnt_run", 64'(bus.gnt), 64'(ew));
      end
      chk("ack_err_excl", 64'(|bus.ack && |bus.err), 64'd0);
      if (drop && cyc == 1) begin
        bus.req = 2'b00;
        bus.req0_st = ~s0;
        bus.req1_st = ~s1;
        bus.req0_rnd = ~r0;
        bus.req1_rnd = ~r1;
      end
      seen = |bus.ack || |bus.err;
    end
    chk("event_cycle", 64'(cyc), 64'(ecyc));
    chk("ack", 64'(bus.ack), 64'(eack));
    chk("err", 64'(bus.err), 64'(eerr));
    chk("gnt_evt", 64'(bus.gnt), 64'(eack));
    chk("start_cycles", 64'(nstart), 64'(ecyc - 1));
    if (eack != 2'b00) last_res = cres;
    chkw("res_st_evt", bus.res_st, last_res);
    ptr_m = ew == 2'b01;
    @(negedge clk);
    bus.req = 2'b00;
    @(posedge clk);
    #1;
    chk("busy_after", 64'(bus.busy), 64'd0);
    chk("pulse_end", 64'({bus.ack, bus.err, bus.gnt}), 64'd0);
    chkw("res_st_hold", bus.res_st, last_res);
  endtask
  // model: both requesting -> side named by the pointer; legal rounds 1..MAX_RND; ack one cycle after done
  task automatic apply_m(input logic [1:0] rq, input logic [4:0] r0, input logic [4:0] r1, input int d, input logic drop);
    logic w, legal;
    logic [4:0] rw;
    logic [1:0] oh;
    w = rq == 2'b11 ? ptr_m : rq[1];
    rw = w ? r1 : r0;
    legal = rw >= 1 && rw <= MAX_RND;
    oh = w ? 2'b10 : 2'b01;
    apply(rq, r0, r1, d, drop, legal ? d + 1 : 1, legal ? oh : 2'b00, legal ? 2'b00 : oh);
  endtask
  initial begin
    int k, cyc;
    n_chk = 0;
    n_fail = 0;
    stray_en = 1'b0;
    core_delay = 0;
    core_res = '0;
    last_res = '0;
    ptr_m = 1'b0;
    bus.req = 2'b00;
    bus.req0_st = '0;
    bus.req1_st = '0;
    bus.req0_rnd = '0;
    bus.req1_rnd = '0;
    tbl[0] = '{2'b01, 5'd12, 5'd1, 12, 1'b0, 13, 2'b01, 2'b00};
    tbl[1] = '{2'b01, 5'd0, 5'd1, 5, 1'b0, 1, 2'b00, 2'b01};
    tbl[2] = '{2'b01, 5'd13, 5'd1, 5, 1'b0, 1, 2'b00, 2'b01};
    tbl[3] = '{2'b11, 5'd5, 5'd3, 4, 1'b0, 5, 2'b10, 2'b00};
    tbl[4] = '{2'b11, 5'd1, 5'd1, 1, 1'b1, 2, 2'b01, 2'b00};
    tbl[5] = '{2'b10, 5'd1, 5'd31, 3, 1'b0, 1, 2'b00, 2'b10};
    tbl[6] = '{2'b11, 5'd12, 5'd0, 2, 1'b0, 3, 2'b01, 2'b00};
    tbl[7] = '{2'b11, 5'd0, 5'd12, 7, 1'b1, 8, 2'b10, 2'b00};
    tbl[8] = '{2'b01, 5'd4, 5'd1, 0, 1'b0, TIMEOUT + 1, 2'b00, 2'b01};
    tbl[9] = '{2'b01, 5'd4, 5'd1, 3, 1'b0, 4, 2'b01, 2'b00};
    rst = 1'b1;
    #3 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", 64'({bus.gnt, bus.ack, bus.err, bus.busy, bus.perm_start}), 64'd0);
    chkw("rst_res", bus.res_st, '0);
    chkw("rst_perm_in", bus.perm_in, '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    core_delay = 2;
    core_res = rnd_st();
    bus.req0_rnd = 5'd3;
    bus.req1_rnd = 5'd3;
    bus.req = 2'b11;
    k = 0;
    cyc = 0;
    while (k < 4 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (|bus.ack) begin
        chk("hold_order", 64'(bus.ack), k % 2 == 1 ? 64'd2 : 64'd1);
        k++;
      end
    end
    chk("hold_count", 64'(k), 64'd4);
    @(negedge clk);
    bus.req = 2'b00;
    last_res = core_res;
    ptr_m = 1'b0;
    for (int i = 0; i < 10; i++)
      apply(tbl[i].rq, tbl[i].r0, tbl[i].r1, tbl[i].d, tbl[i].drop, tbl[i].ecyc, tbl[i].eack, tbl[i].eerr);
    @(negedge clk);
    core_delay = 0;
    bus.req0_rnd = 5'd6;
    bus.req = 2'b01;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_run", 64'(bus.perm_start), 64'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_ctrl", 64'({bus.gnt, bus.ack, bus.err, bus.busy, bus.perm_start}), 64'd0);
    chk("async_rst_rnd", 64'(bus.perm_rnd), 64'd0);
    chkw("async_rst_res", bus.res_st, '0);
    chkw("async_rst_in", bus.perm_in, '0);
    bus.req = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    last_res = '0;
    ptr_m = 1'b0;
    apply(2'b11, 5'd2, 5'd2, 2, 1'b0, 3, 2'b01, 2'b00);
    apply(2'b10, 5'd2, 5'd2, 2, 1'b0, 3, 2'b10, 2'b00);
    stray_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [4:0] r0, r1;
      r0 = $urandom_range(0, 4) == 0 ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 12));
      r1 = $urandom_range(0, 4) == 0 ? 5'($urandom_range(0, 31)) : 5'($urandom_range(1, 12));
      apply_m(2'($urandom_range(1, 3)), r0, r1, $urandom_range(1, 20), 1'($urandom_range(0, 1)));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
